// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin N-master to single-memory arbiter with ack timeout
module mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_rd_en_i,
    input  logic [NUM_MASTERS-1:0]            m_wr_en_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
    output logic [DATA_WIDTH-1:0]             m_data_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              mem_rd_en_o,
    output logic                              mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0]             mem_addr_o,
    output logic [DATA_WIDTH-1:0]             mem_data_o,
    input  logic [DATA_WIDTH-1:0]             mem_data_i,
    input  logic                              mem_ack_i,
    output logic                              busy_o
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state;
    logic [GW-1:0]          last_grant;
    logic [GW-1:0]          grant;
    logic [GW-1:0]          next_grant;
    logic                   found;
    logic [CW-1:0]          tmo_cnt;
    logic [NUM_MASTERS-1:0] req;

    assign req = m_rd_en_i | m_wr_en_i;

    // Scan starts just after the previous winner so no requester can be starved.
    always_comb begin
        int idx;
        idx        = 0;
        found      = 1'b0;
        next_grant = last_grant;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = (int'(last_grant) + i) % NUM_MASTERS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                next_grant = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= GW'(NUM_MASTERS - 1);
            grant       <= '0;
            tmo_cnt     <= '0;
            mem_rd_en_o <= 1'b0;
            mem_wr_en_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            m_data_o    <= '0;
            m_ack_o     <= '0;
            m_err_o     <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (found) begin
                        grant       <= next_grant;
                        last_grant  <= next_grant;
                        mem_addr_o  <= m_addr_i[int'(next_grant)*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_data_o  <= m_data_i[int'(next_grant)*DATA_WIDTH +: DATA_WIDTH];
                        // A simultaneous read and write is resolved as a write.
                        mem_wr_en_o <= m_wr_en_i[next_grant];
                        mem_rd_en_o <= !m_wr_en_i[next_grant];
                        busy_o      <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        mem_rd_en_o    <= 1'b0;
                        mem_wr_en_o    <= 1'b0;
                        if (mem_rd_en_o) begin
                            m_data_o <= mem_data_i;
                        end
                        m_ack_o[grant] <= 1'b1;
                        state          <= RESP;
                    end else if (TIMEOUT != 0 && tmo_cnt == TLAST) begin
                        mem_rd_en_o    <= 1'b0;
                        mem_wr_en_o    <= 1'b0;
                        m_data_o       <= '0;
                        m_ack_o[grant] <= 1'b1;
                        m_err_o[grant] <= 1'b1;
                        state          <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    m_ack_o <= '0;
                    m_err_o <= '0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a two-master, TIMEOUT=4 build
module tb_mem_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM-1:0]     m_rd_en_i = '0;
    logic [NM-1:0]     m_wr_en_i = '0;
    logic [NM*AW-1:0]  m_addr_i = '0;
    logic [NM*DW-1:0]  m_data_i = '0;
    logic [DW-1:0]     m_data_o;
    logic [NM-1:0]     m_ack_o;
    logic [NM-1:0]     m_err_o;
    logic              mem_rd_en_o;
    logic              mem_wr_en_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_data_o;
    logic [DW-1:0]     mem_data_i = '0;
    logic              mem_ack_i = 1'b0;
    logic              busy_o;

    mem_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_rd_en_i(m_rd_en_i), .m_wr_en_i(m_wr_en_i),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i),
        .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
    } cmd_t;

    typedef struct {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] data;
        bit          chk_data;
    } resp_t;

    cmd_t        cmd_q[$];
    resp_t       resp_q[$];
    logic [31:0] mem_arr [0:255];
    int          checks = 0;
    int          errors = 0;
    bit          mem_resp_en = 1'b1;
    bit [NM-1:0] hold = '0;
    bit          prev_strobe = 1'b0;
    int          cur_len = 0;
    int          cur_len_exp = 0;
    int          ack_cnt = 0;

    task automatic push_cmd(input int m, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input int len);
        cmd_t c;
        c.m = m; c.wr = wr; c.addr = addr; c.data = data; c.len = len;
        cmd_q.push_back(c);
    endtask

    task automatic push_resp(input logic [1:0] ack, input logic [1:0] err,
                             input logic [31:0] data, input bit chk_data);
        resp_t r;
        r.ack = ack; r.err = err; r.data = data; r.chk_data = chk_data;
        resp_q.push_back(r);
    endtask

    task automatic issue(input int k, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data);
        m_addr_i[k*AW +: AW] = addr;
        m_data_i[k*DW +: DW] = data;
        m_rd_en_i[k] = rd;
        m_wr_en_i[k] = wr;
    endtask

    // One clock: memory model, command/response scoreboard and master-side request release.
    task automatic tick();
        bit    strobe;
        cmd_t  c;
        resp_t r;
        @(negedge clk);
        mem_ack_i = 1'b0;
        if ((mem_rd_en_o || mem_wr_en_o) && mem_resp_en && rst_n) begin
            mem_ack_i = 1'b1;
            if (mem_wr_en_o) mem_arr[mem_addr_o[7:0]] = mem_data_o;
            else             mem_data_i = mem_arr[mem_addr_o[7:0]];
        end
        strobe = mem_rd_en_o | mem_wr_en_o;
        if (strobe && !prev_strobe) begin
            checks++;
            if (cmd_q.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected addr=%h expected no command", mem_addr_o);
                cur_len_exp = 0;
            end else begin
                c = cmd_q.pop_front();
                checks++;
                if (mem_addr_o !== c.addr) begin
                    errors++;
                    $display("FAIL cmd_addr master=%0d got=%h exp=%h", c.m, mem_addr_o, c.addr);
                end
                checks++;
                if ({mem_rd_en_o, mem_wr_en_o} !== {!c.wr, c.wr}) begin
                    errors++;
                    $display("FAIL cmd_op got rd/wr=%b%b exp=%b%b", mem_rd_en_o, mem_wr_en_o, !c.wr, c.wr);
                end
                if (c.wr) begin
                    checks++;
                    if (mem_data_o !== c.data) begin
                        errors++;
                        $display("FAIL cmd_wdata got=%h exp=%h", mem_data_o, c.data);
                    end
                end
                cur_len_exp = c.len;
            end
            cur_len = 1;
        end else if (strobe) begin
            cur_len++;
        end else if (prev_strobe && cur_len_exp != 0) begin
            checks++;
            if (cur_len !== cur_len_exp) begin
                errors++;
                $display("FAIL strobe_len got=%0d exp=%0d", cur_len, cur_len_exp);
            end
        end
        prev_strobe = strobe;
        if (m_ack_o !== '0) begin
            checks++;
            if (resp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected ack=%b expected none", m_ack_o);
            end else begin
                r = resp_q.pop_front();
                checks++;
                if (m_ack_o !== r.ack) begin
                    errors++;
                    $display("FAIL resp_ack got=%b exp=%b", m_ack_o, r.ack);
                end
                checks++;
                if (m_err_o !== r.err) begin
                    errors++;
                    $display("FAIL resp_err got=%b exp=%b", m_err_o, r.err);
                end
                if (r.chk_data) begin
                    checks++;
                    if (m_data_o !== r.data) begin
                        errors++;
                        $display("FAIL resp_data got=%h exp=%h", m_data_o, r.data);
                    end
                end
            end
            for (int k = 0; k < NM; k++) begin
                if (m_ack_o[k] && !hold[k]) begin
                    m_rd_en_i[k] = 1'b0;
                    m_wr_en_i[k] = 1'b0;
                end
            end
            ack_cnt++;
        end
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while ((cmd_q.size() != 0 || resp_q.size() != 0 || busy_o || m_rd_en_i != 0 ||
                m_wr_en_i != 0) && i < 100) begin
            tick();
            i++;
        end
        tick();
        checks++;
        if (cmd_q.size() != 0 || resp_q.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain cmds=%0d resps=%0d busy=%b exp 0 0 0",
                     name, cmd_q.size(), resp_q.size(), busy_o);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m_rd_en_i = '0;
        m_wr_en_i = '0;
        hold = '0;
        mem_resp_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({mem_rd_en_o, mem_wr_en_o, busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got rd/wr/busy=%b%b%b exp=000", mem_rd_en_o, mem_wr_en_o, busy_o);
        end
        checks++;
        if ({m_ack_o, m_err_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ack got ack=%b err=%b exp 00 00", m_ack_o, m_err_o);
        end
        checks++;
        if (m_data_o !== 32'h0 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got data=%h addr=%h exp 0 0", m_data_o, mem_addr_o);
        end
        apply_reset();
    endtask

    task automatic test_read();
        push_cmd(0, 1'b0, 32'h10, 32'h0, 1);
        push_resp(2'b01, 2'b00, 32'hDEADBEEF, 1'b1);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0);
        wait_done("read");
    endtask

    task automatic test_round_robin();
        int i;
        apply_reset();
        for (int n = 0; n < 2; n++) begin
            push_cmd(0, 1'b0, 32'h30, 32'h0, 1);
            push_resp(2'b01, 2'b00, 32'h30303030, 1'b1);
            push_cmd(1, 1'b0, 32'h40, 32'h0, 1);
            push_resp(2'b10, 2'b00, 32'h40404040, 1'b1);
        end
        hold = 2'b11;
        ack_cnt = 0;
        issue(0, 1'b1, 1'b0, 32'h30, 32'h0);
        issue(1, 1'b1, 1'b0, 32'h40, 32'h0);
        i = 0;
        while (ack_cnt < 4 && i < 100) begin
            tick();
            i++;
        end
        m_rd_en_i = '0;
        hold = '0;
        checks++;
        if (ack_cnt !== 4) begin
            errors++;
            $display("FAIL rr_acks got=%0d exp=4", ack_cnt);
        end
        wait_done("rr");
    endtask

    task automatic test_write_read();
        apply_reset();
        push_cmd(0, 1'b0, 32'h10, 32'h0, 1);
        push_resp(2'b01, 2'b00, 32'hDEADBEEF, 1'b1);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0);
        wait_done("wr_pre");
        push_cmd(1, 1'b1, 32'h20, 32'hCAFEF00D, 1);
        push_resp(2'b10, 2'b00, 32'hDEADBEEF, 1'b1);
        issue(1, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
        wait_done("write");
        push_cmd(0, 1'b0, 32'h20, 32'h0, 1);
        push_resp(2'b01, 2'b00, 32'hCAFEF00D, 1'b1);
        issue(0, 1'b1, 1'b0, 32'h20, 32'h0);
        wait_done("readback");
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_resp_en = 1'b0;
        push_cmd(1, 1'b0, 32'h50, 32'h0, 4);
        push_resp(2'b10, 2'b10, 32'h0, 1'b1);
        issue(1, 1'b1, 1'b0, 32'h50, 32'h0);
        wait_done("timeout");
        mem_resp_en = 1'b1;
        push_cmd(0, 1'b0, 32'h10, 32'h0, 1);
        push_resp(2'b01, 2'b00, 32'hDEADBEEF, 1'b1);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0);
        wait_done("post_timeout");
    endtask

    task automatic test_both_ops();
        apply_reset();
        push_cmd(0, 1'b1, 32'h60, 32'h12345678, 1);
        push_resp(2'b01, 2'b00, 32'h0, 1'b1);
        issue(0, 1'b1, 1'b1, 32'h60, 32'h12345678);
        wait_done("both_ops");
        checks++;
        if (mem_arr[8'h60] !== 32'h12345678) begin
            errors++;
            $display("FAIL both_ops_mem got=%h exp=12345678", mem_arr[8'h60]);
        end
    endtask

    task automatic test_reset_mid_wait();
        int i;
        apply_reset();
        mem_resp_en = 1'b0;
        push_cmd(1, 1'b0, 32'h40, 32'h0, 0);
        issue(1, 1'b1, 1'b0, 32'h40, 32'h0);
        i = 0;
        while (!mem_rd_en_o && i < 20) begin
            tick();
            i++;
        end
        tick();
        checks++;
        if (mem_rd_en_o !== 1'b1) begin
            errors++;
            $display("FAIL midwait_strobe got=%b exp=1", mem_rd_en_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en_o, mem_wr_en_o, busy_o, m_ack_o} !== 5'b0) begin
            errors++;
            $display("FAIL midwait_async got rd/wr/busy/ack=%b%b%b%b exp=00000",
                     mem_rd_en_o, mem_wr_en_o, busy_o, m_ack_o);
        end
        m_rd_en_i = '0;
        mem_resp_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        push_cmd(0, 1'b0, 32'h10, 32'h0, 1);
        push_resp(2'b01, 2'b00, 32'hDEADBEEF, 1'b1);
        push_cmd(1, 1'b0, 32'h40, 32'h0, 1);
        push_resp(2'b10, 2'b00, 32'h40404040, 1'b1);
        issue(1, 1'b1, 1'b0, 32'h40, 32'h0);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0);
        wait_done("after_reset");
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem_arr[a] = 32'h0;
        mem_arr[8'h10] = 32'hDEADBEEF;
        mem_arr[8'h30] = 32'h30303030;
        mem_arr[8'h40] = 32'h40404040;
        test_reset();
        test_read();
        test_round_robin();
        test_write_read();
        test_timeout();
        test_both_ops();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
